// File: rtl/dmem_arbiter.sv
// Single-port data-RAM arbiter. The CPU has fixed priority, and the loader and write-back
// channels share the port round-robin. A starvation guard forces one DMA grant past the CPU.
module dmem_arbiter #(
  parameter int unsigned ADDR_W       = 6,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              clk_sys,
  input  logic              rst_sync,
  // CPU data port
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  // ROM-to-RAM loader (write-only)
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  // RAM-to-verify write-back (read-only)
  input  logic              wb_req,
  input  logic [ADDR_W-1:0] wb_addr,
  output logic              wb_gnt,
  output logic [DATA_W-1:0] wb_rdata,
  output logic              wb_rvalid,
  // RAM port
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [15:0]       conflict_cnt
);

  localparam logic [7:0] StarveMax = 8'(STARVE_LIMIT);

  typedef enum logic [1:0] {GntNone, GntCpu, GntLd, GntWb} gnt_e;

  gnt_e        gnt_sel;
  logic        dma_req;
  logic        force_dma;
  logic        multi_req;

  logic        rr_ptr_q, rr_ptr_d;
  logic [7:0]  starve_cnt_q, starve_cnt_d;
  logic [15:0] conflict_cnt_q, conflict_cnt_d;
  logic        cpu_rvalid_q, cpu_rvalid_d;
  logic        wb_rvalid_q, wb_rvalid_d;

  // Grant decision; forced to none while reset is held so every strobe reads 0.
  always_comb begin
    dma_req   = ld_req | wb_req;
    force_dma = dma_req && (starve_cnt_q == StarveMax);
    multi_req = (cpu_req & ld_req) | (cpu_req & wb_req) | (ld_req & wb_req);
    gnt_sel   = GntNone;
    if (!rst_sync) begin
      if (cpu_req && !force_dma) begin
        gnt_sel = GntCpu;
      end else if (ld_req && (!wb_req || !rr_ptr_q)) begin
        gnt_sel = GntLd;
      end else if (wb_req) begin
        gnt_sel = GntWb;
      end
    end
  end

  always_comb begin
    rr_ptr_d       = rr_ptr_q;
    starve_cnt_d   = starve_cnt_q;
    conflict_cnt_d = conflict_cnt_q;
    cpu_rvalid_d   = (gnt_sel == GntCpu) && !cpu_we;
    wb_rvalid_d    = (gnt_sel == GntWb);

    if (gnt_sel == GntLd) rr_ptr_d = 1'b1;
    if (gnt_sel == GntWb) rr_ptr_d = 1'b0;

    if ((gnt_sel == GntLd) || (gnt_sel == GntWb)) begin
      starve_cnt_d = '0;
    end else if (dma_req && (gnt_sel == GntCpu) && (starve_cnt_q != StarveMax)) begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end

    if (multi_req && (conflict_cnt_q != 16'hFFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_sys or posedge rst_sync) begin
    if (rst_sync) begin
      rr_ptr_q       <= 1'b0;
      starve_cnt_q   <= '0;
      conflict_cnt_q <= '0;
      cpu_rvalid_q   <= 1'b0;
      wb_rvalid_q    <= 1'b0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      starve_cnt_q   <= starve_cnt_d;
      conflict_cnt_q <= conflict_cnt_d;
      cpu_rvalid_q   <= cpu_rvalid_d;
      wb_rvalid_q    <= wb_rvalid_d;
    end
  end

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    unique case (gnt_sel)
      GntCpu: begin
        ram_en    = 1'b1;
        ram_we    = cpu_we;
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
      end
      GntLd: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = ld_addr;
        ram_wdata = ld_wdata;
      end
      GntWb: begin
        ram_en   = 1'b1;
        ram_addr = wb_addr;
      end
      default: ;
    endcase
  end

  assign cpu_stall    = cpu_req && !rst_sync && (gnt_sel != GntCpu);
  assign ld_gnt       = (gnt_sel == GntLd);
  assign wb_gnt       = (gnt_sel == GntWb);
  assign cpu_rdata    = ram_rdata;
  assign wb_rdata     = ram_rdata;
  assign cpu_rvalid   = cpu_rvalid_q;
  assign wb_rvalid    = wb_rvalid_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule
